// File: rtl/gsim_band_mul_pkg.sv
// gsim_band_mul_pkg: sizes, FSM encoding and sign-extension helper for gsim_band_mul.
// GSIM_BMUL_ROUND_EN lengthens FLUSH by one cycle to cover the extra rounding stage.
package gsim_band_mul_pkg;
   localparam int GSIM_N  = 16;
   localparam int GSIM_XW = 32;
   localparam int GSIM_BW = 38;
   localparam int GSIM_CW = $clog2(GSIM_N);
`ifdef GSIM_BMUL_ROUND_EN
   localparam int FLUSH_LEN = 4;
`else
   localparam int FLUSH_LEN = 3;
`endif
   typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
   function automatic logic signed [GSIM_BW-1:0] sx(input logic [GSIM_XW-1:0] v);
      return {{(GSIM_BW-GSIM_XW){v[GSIM_XW-1]}}, v};
   endfunction
endpackage

// File: rtl/gsim_band_mul_mac.sv
// gsim_band_mul_mac: combinational 7-tap symmetric band product (20,-13,6,-1) over w[0..6], shift-add only.
module gsim_band_mul_mac
   import gsim_band_mul_pkg::*;
(
   input  logic [6:0][GSIM_XW-1:0] w,
   output logic [GSIM_BW-1:0]      b
);
   logic signed [GSIM_BW-1:0] s0, s1, s2, s3;
   always_comb begin
      s0 = sx(w[3]);
      s1 = sx(w[2]) + sx(w[4]);
      s2 = sx(w[1]) + sx(w[5]);
      s3 = sx(w[0]) + sx(w[6]);
      b  = (s0 <<< 4) + (s0 <<< 2) - (s1 <<< 3) - (s1 <<< 2) - s1 + (s2 <<< 2) + (s2 <<< 1) - s3;
   end
endmodule

// File: rtl/gsim_band_mul.sv
// gsim_band_mul: streams b = M*x for the fixed banded GSIM matrix over 16-entry frames.
// GSIM_BMUL_ROUND_EN adds a round-half-up / 16-bit saturation output stage.
module gsim_band_mul
   import gsim_band_mul_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               in_en,
   input  logic [GSIM_XW-1:0] x_in,
   output logic               busy,
   output logic               out_valid,
   output logic [GSIM_BW-1:0] b_out,
   output logic               frame_done
);
   state_t state_q, state_d;
   logic [GSIM_CW-1:0] cnt_q, cnt_d;
   logic [6:0][GSIM_XW-1:0] win_q, win_d, win_sh;
   logic [GSIM_BW-1:0] b_q, b_d, mac_b;
   logic v_q, v_d, fd_q, fd_d, accept;

   assign accept = in_en && state_q != FLUSH;
   assign busy   = state_q == FLUSH;
   // The product is taken on the shifted window so b is registered on the accepting edge
   assign win_sh = {(state_q == FLUSH) ? {GSIM_XW{1'b0}} : x_in, win_q[6:1]};

   gsim_band_mul_mac u_mac (.w(win_sh), .b(mac_b));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      win_d   = win_q;
      b_d     = b_q;
      v_d     = 1'b0;
      fd_d    = 1'b0;
      if (accept) begin
         win_d = win_sh;
         cnt_d = cnt_q + 1'b1;
      end
      case (state_q)
         IDLE: state_d = accept ? FILL : IDLE;
         FILL: state_d = (accept && cnt_q == GSIM_CW'(2)) ? RUN : FILL;
         RUN: if (accept) begin
            v_d = 1'b1;
            b_d = mac_b;
            if (cnt_q == GSIM_CW'(GSIM_N - 1)) begin
               state_d = FLUSH;
               cnt_d   = '0;
            end
         end
         FLUSH: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q < GSIM_CW'(3)) begin
               win_d = win_sh;
               v_d   = 1'b1;
               b_d   = mac_b;
               fd_d  = cnt_q == GSIM_CW'(2);
            end
            if (cnt_q == GSIM_CW'(FLUSH_LEN - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               win_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         win_q   <= '0;
         b_q     <= '0;
         v_q     <= 1'b0;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         win_q   <= win_d;
         b_q     <= b_d;
         v_q     <= v_d;
         fd_q    <= fd_d;
      end
   end

`ifdef GSIM_BMUL_ROUND_EN
   localparam logic signed [GSIM_BW-1:0] QMAX = GSIM_BW'(32767);
   localparam logic signed [GSIM_BW-1:0] QMIN = GSIM_BW'(-32768);
   logic signed [GSIM_BW-1:0] r_i;
   logic [GSIM_BW-1:0] r_q, r_d;
   logic rv_q, rv_d, rfd_q, rfd_d;

   always_comb begin
      r_i   = signed'(b_q + GSIM_BW'(32'h8000)) >>> 16;
      r_d   = r_q;
      rv_d  = v_q;
      rfd_d = fd_q;
      if (v_q)
         r_d = (r_i > QMAX) ? {{(GSIM_BW-32){1'b0}}, 32'h7FFF0000} :
               (r_i < QMIN) ? {{(GSIM_BW-32){1'b1}}, 32'h80000000} : {r_i[GSIM_BW-17:0], 16'h0};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q   <= '0;
         rv_q  <= 1'b0;
         rfd_q <= 1'b0;
      end else begin
         r_q   <= r_d;
         rv_q  <= rv_d;
         rfd_q <= rfd_d;
      end
   end

   assign out_valid  = rv_q;
   assign b_out      = r_q;
   assign frame_done = rfd_q;
`else
   assign out_valid  = v_q;
   assign b_out      = b_q;
   assign frame_done = fd_q;
`endif
endmodule

// File: tb/tb_gsim_band_mul.sv
// tb_gsim_band_mul: random and directed frames against a per-cycle expectation model of b = M*x.
module tb_gsim_band_mul;
   localparam int N = 16, MAXC = 8192;
`ifdef GSIM_BMUL_ROUND_EN
   localparam int L = 1, FL = 4;
`else
   localparam int L = 0, FL = 3;
`endif
   logic clk = 1'b0, reset = 1'b1, in_en = 1'b0;
   logic [31:0] x_in = '0;
   logic busy, out_valid, frame_done;
   logic [37:0] b_out;
   int total = 0, bad = 0, ec = 0, e = 0, k = 0, fl = 0, nlog = 0;
   logic signed [31:0] xs [N];
   logic [31:0] fx [N];
   bit ev [MAXC];
   bit efd [MAXC];
   bit ebz [MAXC];
   logic [37:0] eb [MAXC];
   logic [37:0] lg [64];
   int cf [4] = '{20, -13, 6, -1};
   int t2 [N] = '{12, -1, 5, 4, 4, 4, 4, 4, 4, 4, 4, 4, 4, 5, -1, 12};

   always #5 clk = ~clk;

   gsim_band_mul dut (
      .clk(clk), .reset(reset), .in_en(in_en), .x_in(x_in),
      .busy(busy), .out_valid(out_valid), .b_out(b_out), .frame_done(frame_done)
   );

   task automatic chk(input string n, input logic [37:0] got, input logic [37:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at edge %0d: got %h want %h", n, ec, got, want);
      end
   endtask

   function automatic logic [37:0] bref(input int i);
      longint s = 0;
`ifdef GSIM_BMUL_ROUND_EN
      longint q;
`endif
      for (int d = -3; d <= 3; d++)
         if (i + d >= 0 && i + d < N) s += cf[d < 0 ? -d : d] * longint'(xs[i + d]);
`ifdef GSIM_BMUL_ROUND_EN
      q = (s + 32768) >>> 16;
      q = q > 32767 ? 32767 : q < -32768 ? -32768 : q;
      s = q * 65536;
`endif
      return s[37:0];
   endfunction

   task automatic sched(input int idx, input logic [37:0] v, input bit fd);
      if (idx < MAXC) begin
         ev[idx]  = 1'b1;
         eb[idx]  = v;
         efd[idx] = fd;
      end
   endtask

   // Model of the edge e about to happen: what becomes visible after it and later
   task automatic step(input logic en, input logic [31:0] x, input logic r);
      if (r) begin
         k  = 0;
         fl = 0;
         for (int i = e; i < e + 8 && i < MAXC; i++) begin
            ev[i]  = 1'b0;
            efd[i] = 1'b0;
            ebz[i] = 1'b0;
         end
      end else if (fl > 0) fl--;
      else if (en) begin
         xs[k] = x;
         k++;
         if (k >= 4) sched(e + L, bref(k - 4), 1'b0);
         if (k == N) begin
            for (int j = 1; j <= 3; j++) sched(e + L + j, bref(N - 4 + j), j == 3);
            for (int j = 0; j < FL; j++) if (e + j < MAXC) ebz[e + j] = 1'b1;
            fl = FL;
            k  = 0;
         end
      end
   endtask

   task automatic tick(input logic en, input logic [31:0] x, input logic r);
      reset = r;
      in_en = en;
      x_in  = x;
      e++;
      step(en, x, r);
      @(negedge clk);
   endtask

   task automatic send_frame(input int mode);
      int g;
      for (int i = 0; i < N; i++) begin
         g = mode == 0 ? 0 : mode == 1 ? 1 : int'($urandom_range(0, 2));
         repeat (g) tick(1'b0, $urandom, 1'b0);
         tick(1'b1, fx[i], 1'b0);
      end
      repeat (8) tick(1'b0, $urandom, 1'b0);
   endtask

   always @(posedge clk) ec <= ec + 1;

   always @(negedge clk) begin
      if (ec > 0 && ec < MAXC) begin
         chk("out_valid", {37'b0, out_valid}, {37'b0, ev[ec]});
         chk("busy", {37'b0, busy}, {37'b0, ebz[ec]});
         chk("frame_done", {37'b0, frame_done}, {37'b0, ev[ec] & efd[ec]});
         if (ev[ec]) chk("b_out", b_out, eb[ec]);
      end
      if (out_valid && nlog < 64) begin
         lg[nlog] = b_out;
         nlog++;
      end
   end

   initial begin
      tick(1'b0, 32'h0, 1'b1);
      tick(1'b0, 32'h0, 1'b1);
      chk("reset_b_out", b_out, 38'h0);
      repeat (2) tick(1'b0, 32'h0, 1'b0);
      // Impulse
      foreach (fx[i]) fx[i] = (i == 0) ? 32'h00010000 : 32'h0;
      nlog = 0;
      send_frame(0);
      chk("impulse_count", 38'(nlog), 38'(N));
      chk("impulse_b0", lg[0], 38'(longint'(20) * 65536));
      chk("impulse_b1", lg[1], 38'(longint'(-13) * 65536));
      chk("impulse_b2", lg[2], 38'(longint'(6) * 65536));
      chk("impulse_b3", lg[3], 38'(longint'(-1) * 65536));
      chk("impulse_b4", lg[4], 38'h0);
      chk("impulse_b15", lg[15], 38'h0);
      // All ones, back-to-back then every other cycle
      foreach (fx[i]) fx[i] = 32'h00010000;
      nlog = 0;
      send_frame(0);
      for (int i = 0; i < N; i++) chk("ones_b", lg[i], 38'(longint'(t2[i]) * 65536));
      nlog = 0;
      send_frame(1);
      chk("gap_count", 38'(nlog), 38'(N));
      chk("gap_b8", lg[8], 38'h40000);
      chk("gap_b15", lg[15], 38'hC0000);
      // Alternating full scale
      foreach (fx[i]) fx[i] = (i % 2 == 0) ? 32'h7FFF0000 : 32'h80010000;
      nlog = 0;
      send_frame(0);
`ifdef GSIM_BMUL_ROUND_EN
      chk("alt_b4", lg[4], 38'h007FFF0000);
      chk("alt_b5", lg[5], 38'(longint'(-32768) * 65536));
`else
      chk("alt_b4", lg[4], 38'(longint'(60 * 32767) * 65536));
      chk("alt_b5", lg[5], 38'(longint'(-60 * 32767) * 65536));
`endif
      // Reset mid-frame, then impulse
      nlog = 0;
      repeat (8) tick(1'b1, $urandom, 1'b0);
      tick(1'b0, 32'h0, 1'b1);
      chk("partial_count", 38'(nlog), (L == 1) ? 38'd4 : 38'd5);
      repeat (3) tick(1'b0, $urandom, 1'b0);
      foreach (fx[i]) fx[i] = (i == 0) ? 32'h00010000 : 32'h0;
      nlog = 0;
      send_frame(2);
      chk("reimpulse_count", 38'(nlog), 38'(N));
      chk("reimpulse_b0", lg[0], 38'h140000);
      chk("reimpulse_b1", lg[1], 38'(longint'(-13) * 65536));
      // in_en held high for 2N cycles
      nlog = 0;
      repeat (2 * N) tick(1'b1, $urandom, 1'b0);
      repeat (8) tick(1'b0, 32'h0, 1'b0);
      chk("stream_count", 38'(nlog), (L == 1) ? 38'd25 : 38'd26);
      tick(1'b0, 32'h0, 1'b1);
      repeat (2) tick(1'b0, 32'h0, 1'b0);
      // Random frames
      repeat (8) begin
         bit big = $urandom_range(0, 1) == 1;
         foreach (fx[i]) fx[i] = big ? $urandom : 32'($urandom_range(0, 262143)) - 32'h20000;
         nlog = 0;
         send_frame(int'($urandom_range(0, 2)));
         chk("rand_count", 38'(nlog), 38'(N));
      end
`ifdef GSIM_BMUL_ROUND_EN
      foreach (fx[i]) fx[i] = 32'h00008000;
      nlog = 0;
      send_frame(0);
      chk("half_b8", lg[8], 38'h20000);
      foreach (fx[i]) fx[i] = 32'h7FFF0000;
      nlog = 0;
      send_frame(0);
      chk("sat_b8", lg[8], 38'h007FFF0000);
`endif
      repeat (4) tick(1'b0, 32'h0, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
